// File: rtl/sm83_dbg_seq.sv
// Host-side SM83 debug sequencer: turns one high-level request into command bytes on the
// toggle handshake, collects tagged reply nibbles and assembles a CPU state snapshot.
module sm83_dbg_seq #(
    parameter int TIMEOUT  = 1023,
    parameter int DUMP_MAX = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  cmd,
    input  logic [15:0] cmd_arg,
    input  logic [1:0]  cmd_idx,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        done,
    output logic        err,
    output logic [3:0]  snap_status,
    output logic [3:0]  snap_f,
    output logic [7:0]  snap_probe,
    output logic [15:0] snap_pc,
    output logic [15:0] snap_sp,
    output logic [15:0] snap_wz,
    output logic        snap_valid,
    output logic [7:0]  dbg_rx_data,
    output logic        dbg_rx_valid,
    output logic        dbg_rx_seq,
    input  logic        dbg_rx_ack,
    input  logic [7:0]  dbg_tx_data,
    input  logic        dbg_tx_seq,
    output logic        dbg_tx_ack
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DUMP_MAX + 5);

    localparam logic [2:0] C_HALT    = 3'd0;
    localparam logic [2:0] C_CONT    = 3'd1;
    localparam logic [2:0] C_STEP    = 3'd2;
    localparam logic [2:0] C_SETBP   = 3'd3;
    localparam logic [2:0] C_DUMP    = 3'd4;
    localparam logic [2:0] C_NOINC   = 3'd5;
    localparam logic [2:0] C_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    state_t        state_reg;
    logic [2:0]    cmd_reg;
    logic [15:0]   arg_reg;
    logic [1:0]    idx_reg;
    logic [CW-1:0] byte_cnt_reg;
    logic [TW-1:0] tmo_reg;
    logic [15:0]   mask_reg;
    logic          got_reply_reg;
    logic          ready_reg;
    logic          done_reg;
    logic          err_reg;
    logic          snap_valid_reg;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg;
    logic          rx_seq_reg;
    logic          tx_ack_reg;

    logic          reply_present;
    logic          rx_acked;
    logic          tmo_hit;
    logic [3:0]    reply_tag;
    logic [3:0]    reply_nib;
    logic [15:0]   mask_next;
    logic [3:0]    bp_nib;
    logic [7:0]    byte_next;

    always_comb begin
        reply_present = (dbg_tx_seq != tx_ack_reg);
        rx_acked      = (dbg_rx_ack == rx_seq_reg);
        tmo_hit       = (tmo_reg == TW'(TIMEOUT));
        reply_tag     = dbg_tx_data[7:4];
        reply_nib     = dbg_tx_data[3:0];
        mask_next     = mask_reg;
        if (reply_present) begin
            mask_next[reply_tag] = 1'b1;
        end
        case (byte_cnt_reg[1:0])
            2'd0:    bp_nib = arg_reg[3:0];
            2'd1:    bp_nib = arg_reg[7:4];
            2'd2:    bp_nib = arg_reg[11:8];
            default: bp_nib = arg_reg[15:12];
        endcase
        case (cmd_reg)
            C_HALT:  byte_next = 8'h00;
            C_CONT:  byte_next = 8'h03;
            C_STEP:  byte_next = 8'h02;
            C_SETBP: byte_next = {2'b10, idx_reg, bp_nib};
            C_NOINC: byte_next = {6'b001000, arg_reg[0], 1'b0};
            default: byte_next = 8'h04;  // PING, and DUMP which polls with PINGs
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cmd_reg        <= '0;
            arg_reg        <= '0;
            idx_reg        <= '0;
            byte_cnt_reg   <= '0;
            tmo_reg        <= '0;
            mask_reg       <= '0;
            got_reply_reg  <= 1'b0;
            ready_reg      <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            snap_valid_reg <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_seq_reg     <= 1'b0;
            tx_ack_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid && ready_reg) begin
                        cmd_reg      <= cmd;
                        arg_reg      <= cmd_arg;
                        idx_reg      <= cmd_idx;
                        byte_cnt_reg <= '0;
                        tmo_reg      <= '0;
                        ready_reg    <= 1'b0;
                        if (cmd == C_ILLEGAL) begin
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            state_reg <= S_FINISH;
                        end else begin
                            if (cmd == C_DUMP) begin
                                mask_reg       <= '0;
                                snap_valid_reg <= 1'b0;
                            end
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A byte left outstanding by an earlier timeout must be acked first.
                    if (rx_acked) begin
                        rx_data_reg   <= byte_next;
                        rx_seq_reg    <= ~rx_seq_reg;
                        rx_valid_reg  <= 1'b1;
                        tmo_reg       <= '0;
                        got_reply_reg <= 1'b0;
                        byte_cnt_reg  <= byte_cnt_reg + CW'(1);
                        state_reg     <= S_WAIT;
                    end else if (tmo_hit) begin
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                        state_reg <= S_FINISH;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (reply_present) begin
                        tx_ack_reg    <= dbg_tx_seq;
                        mask_reg      <= mask_next;
                        got_reply_reg <= 1'b1;
                    end
                    if (rx_acked) begin
                        rx_valid_reg <= 1'b0;
                        if (!(got_reply_reg || reply_present)) begin
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            state_reg <= S_FINISH;
                        end else if (cmd_reg == C_SETBP) begin
                            if (byte_cnt_reg == CW'(4)) begin
                                done_reg  <= 1'b1;
                                state_reg <= S_FINISH;
                            end else begin
                                state_reg <= S_ISSUE;
                            end
                        end else if (cmd_reg == C_DUMP) begin
                            if (mask_next == 16'hFFFF) begin
                                snap_valid_reg <= 1'b1;
                                done_reg       <= 1'b1;
                                state_reg      <= S_FINISH;
                            end else if (byte_cnt_reg == CW'(DUMP_MAX)) begin
                                done_reg  <= 1'b1;
                                err_reg   <= 1'b1;
                                state_reg <= S_FINISH;
                            end else begin
                                state_reg <= S_ISSUE;
                            end
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= S_FINISH;
                        end
                    end else if (tmo_hit) begin
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                        state_reg <= S_FINISH;
                    end else begin
                        tmo_reg <= tmo_reg + TW'(1);
                    end
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // One nibble register per reply tag; bit 2 of the status nibble is reserved as zero.
    for (genvar gi = 0; gi < 16; gi++) begin : g_nib
        logic [3:0] nib_reg;
        logic [3:0] wdata;
        assign wdata = (gi == 0) ? (reply_nib & 4'hB) : reply_nib;
        always_ff @(posedge clk) begin
            if (reset) begin
                nib_reg <= '0;
            end else if (state_reg == S_WAIT && reply_present && reply_tag == 4'(gi)) begin
                nib_reg <= wdata;
            end
        end
    end

    assign snap_status  = g_nib[0].nib_reg;
    assign snap_f       = g_nib[1].nib_reg;
    assign snap_probe   = {g_nib[3].nib_reg, g_nib[2].nib_reg};
    assign snap_pc      = {g_nib[7].nib_reg, g_nib[6].nib_reg, g_nib[5].nib_reg, g_nib[4].nib_reg};
    assign snap_sp      = {g_nib[11].nib_reg, g_nib[10].nib_reg, g_nib[9].nib_reg, g_nib[8].nib_reg};
    assign snap_wz      = {g_nib[15].nib_reg, g_nib[14].nib_reg, g_nib[13].nib_reg, g_nib[12].nib_reg};
    assign snap_valid   = snap_valid_reg;
    assign cmd_ready    = ready_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign dbg_rx_data  = rx_data_reg;
    assign dbg_rx_valid = rx_valid_reg;
    assign dbg_rx_seq   = rx_seq_reg;
    assign dbg_tx_ack   = tx_ack_reg;
endmodule

// File: tb/tb_sm83_dbg_seq.sv
// Randomised scoreboard bench for sm83_dbg_seq: a behavioural debug-port model answers
// command bytes while a monitor checks each finished request against queued expectations.
module tb_sm83_dbg_seq;
    localparam int TMO  = 64;
    localparam int DMAX = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cmd = '0;
    logic [15:0] cmd_arg = '0;
    logic [1:0]  cmd_idx = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready, done, err, snap_valid;
    logic [3:0]  snap_status, snap_f;
    logic [7:0]  snap_probe;
    logic [15:0] snap_pc, snap_sp, snap_wz;
    logic [7:0]  dbg_rx_data;
    logic        dbg_rx_valid, dbg_rx_seq, dbg_tx_ack;
    logic        dbg_rx_ack = 1'b0;
    logic [7:0]  dbg_tx_data = '0;
    logic        dbg_tx_seq = 1'b0;

    always #5 clk = ~clk;

    sm83_dbg_seq #(.TIMEOUT(TMO), .DUMP_MAX(DMAX)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_arg(cmd_arg), .cmd_idx(cmd_idx),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .done(done), .err(err),
        .snap_status(snap_status), .snap_f(snap_f), .snap_probe(snap_probe),
        .snap_pc(snap_pc), .snap_sp(snap_sp), .snap_wz(snap_wz), .snap_valid(snap_valid),
        .dbg_rx_data(dbg_rx_data), .dbg_rx_valid(dbg_rx_valid), .dbg_rx_seq(dbg_rx_seq),
        .dbg_rx_ack(dbg_rx_ack), .dbg_tx_data(dbg_tx_data), .dbg_tx_seq(dbg_tx_seq),
        .dbg_tx_ack(dbg_tx_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- debug port model ----------------
    logic [3:0] port_val[16];
    logic [3:0] ref_nib[16];      // what the snapshot must hold: every reply actually sent
    bit   p_reply = 1, p_ack = 1, p_stuck = 0;
    int   rd = 1, ad = 1, next_tag = 0, pcnt = 0, tg = 0;
    bit   pending = 0;
    logic last_seq = 1'b0;
    logic [7:0] got_q[$];

    initial for (int i = 0; i < 16; i++) begin
        port_val[i] = '0;
        ref_nib[i]  = '0;
    end

    always @(negedge clk) begin
        if (reset) begin
            last_seq = 1'b0;
            pending  = 0;
        end else begin
            if (dbg_rx_seq != last_seq) begin
                last_seq = dbg_rx_seq;
                got_q.push_back(dbg_rx_data);
                pending = 1;
                pcnt    = 0;
            end
            if (pending) begin
                pcnt++;
                if (p_reply && pcnt == rd) begin
                    tg = next_tag;
                    ref_nib[tg] = port_val[tg];
                    dbg_tx_data = {tg[3:0], port_val[tg]};
                    dbg_tx_seq  = ~dbg_tx_seq;
                    if (!p_stuck) next_tag = (next_tag + 1) % 16;
                end
                if (p_ack && pcnt == ad) begin
                    dbg_rx_ack = dbg_rx_seq;
                    pending    = 0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    bit         exp_err_q[$];
    int         exp_n_q[$];
    logic [7:0] exp_byte_q[$];
    bit         exp_sv_q[$];
    bit         exp_rxv_q[$];
    bit         sv_model = 0;

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_err_q.size() == 0) begin
                chk("done_without_request", exp_err_q.size(), 1);
            end else begin
                bit e_err, e_sv, e_rxv;
                int e_n;
                logic [7:0] gb, eb;
                e_err = exp_err_q.pop_front();
                e_n   = exp_n_q.pop_front();
                e_sv  = exp_sv_q.pop_front();
                e_rxv = exp_rxv_q.pop_front();
                chk("err", err, e_err);
                chk("byte_count", got_q.size(), e_n);
                for (int i = 0; i < e_n; i++) begin
                    eb = exp_byte_q.pop_front();
                    gb = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
                    chk("cmd_byte", gb, eb);
                end
                got_q.delete();
                chk("snap_status", snap_status, ref_nib[0]);
                chk("snap_f", snap_f, ref_nib[1]);
                chk("snap_probe", snap_probe, {ref_nib[3], ref_nib[2]});
                chk("snap_pc", snap_pc, {ref_nib[7], ref_nib[6], ref_nib[5], ref_nib[4]});
                chk("snap_sp", snap_sp, {ref_nib[11], ref_nib[10], ref_nib[9], ref_nib[8]});
                chk("snap_wz", snap_wz, {ref_nib[15], ref_nib[14], ref_nib[13], ref_nib[12]});
                chk("snap_valid", snap_valid, e_sv);
                chk("tx_ack_consumed", dbg_tx_ack, dbg_tx_seq);
                chk("rx_valid", dbg_rx_valid, e_rxv);
            end
        end
    end

    function automatic logic [7:0] byte_of(input logic [2:0] c, input logic [15:0] a,
                                           input logic [1:0] ix, input int k);
        int v;
        case (c)
            3'd0:    v = 0;
            3'd1:    v = 3;
            3'd2:    v = 2;
            3'd3:    v = 128 + int'(ix) * 16 + ((int'(a) >> (4 * k)) & 15);
            3'd5:    v = 32 + int'(a[0]) * 2;
            default: v = 4;
        endcase
        return v[7:0];
    endfunction

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic req(input logic [2:0] c, input logic [15:0] a, input logic [1:0] ix,
                       output int lat);
        bit rej, silent, e;
        int n, w;
        rej    = p_ack && !p_reply;
        silent = !p_ack;
        e = 0;
        n = 0;
        if (c == 3'd7) begin
            e = 1;
        end else if (silent || rej) begin
            exp_byte_q.push_back(byte_of(c, a, ix, 0));
            n = 1;
            e = 1;
        end else if (c == 3'd3) begin
            for (int k = 0; k < 4; k++) exp_byte_q.push_back(byte_of(c, a, ix, k));
            n = 4;
        end else if (c == 3'd4) begin
            n = p_stuck ? DMAX : 16;
            e = p_stuck;
            for (int k = 0; k < n; k++) exp_byte_q.push_back(8'h04);
        end else begin
            exp_byte_q.push_back(byte_of(c, a, ix, 0));
            n = 1;
        end
        if (c == 3'd4) sv_model = !silent && !rej && !p_stuck;
        exp_err_q.push_back(e);
        exp_n_q.push_back(n);
        exp_sv_q.push_back(sv_model);
        exp_rxv_q.push_back(silent && c != 3'd7);

        @(negedge clk);
        cmd = c; cmd_arg = a; cmd_idx = ix; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1);
            finish_now();
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            chk("done_timeout", done, 1);
            finish_now();
        end
        $display("REQ cmd=%0d arg=%h idx=%0d err=%0b latency=%0d", c, a, ix, err, lat);
        chk("ready_during_done", cmd_ready, 0);
        @(negedge clk);
        chk("done_pulse_one_cycle", done, 0);
        chk("ready_after_done", cmd_ready, 1);
    endtask

    task automatic rand_port_vals();
        for (int t = 0; t < 16; t++) port_val[t] = 4'($urandom_range(0, 15));
        port_val[0][2] = 1'b0;
    endtask

    int lat;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rx_seq", dbg_rx_seq, 0);
        chk("rst_rx_valid", dbg_rx_valid, 0);
        chk("rst_rx_data", dbg_rx_data, 0);
        chk("rst_tx_ack", dbg_tx_ack, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_snap_pc", snap_pc, 0);

        // PING on an idle port, status reply 0xA
        next_tag = 0; port_val[0] = 4'hA; rd = 2; ad = 3;
        req(3'd6, 16'h0000, 2'd0, lat);
        chk("ping_status", snap_status, 4'hA);

        // HALT with the flags reply arriving late
        next_tag = 1; port_val[1] = 4'h7; rd = 24; ad = 24;
        req(3'd0, 16'h0000, 2'd0, lat);
        chk("halt_f", snap_f, 4'h7);

        // SET_BP idx 2 at 0x1234
        rd = 1; ad = 2;
        req(3'd3, 16'h1234, 2'd2, lat);

        // STEP while running: ack without reply
        p_reply = 0; ad = 3;
        req(3'd2, 16'h0000, 2'd0, lat);
        p_reply = 1;

        // illegal request
        req(3'd7, 16'hFFFF, 2'd3, lat);
        chk("illegal_latency", lat, 1);

        // DUMP starting at tag 5 with pc = 0x0150
        rand_port_vals();
        port_val[4] = 4'h0; port_val[5] = 4'h5; port_val[6] = 4'h1; port_val[7] = 4'h0;
        next_tag = 5; rd = 2; ad = 2;
        req(3'd4, 16'h0000, 2'd0, lat);
        chk("dump_pc", snap_pc, 16'h0150);
        chk("dump_valid", snap_valid, 1);

        // randomised traffic
        for (int t = 0; t < 40; t++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            rand_port_vals();
            p_reply = ($urandom_range(0, 4) != 0);
            rd = $urandom_range(1, 20);
            ad = rd + $urandom_range(0, 10);
            req(c, 16'($urandom), 2'($urandom_range(0, 3)), lat);
            p_reply = 1;
        end

        // DUMP that can never collect all tags stops after DUMP_MAX bytes
        p_stuck = 1; rd = 1; ad = 1;
        req(3'd4, 16'h0000, 2'd0, lat);
        chk("stuck_dump_valid", snap_valid, 0);
        p_stuck = 0;

        // silent port: per-byte timeout
        p_reply = 0; p_ack = 0;
        req(3'd6, 16'h0000, 2'd0, lat);
        chk("timeout_latency_in_range", (lat >= TMO && lat <= TMO + 4), 1);

        chk("pending_expectations", exp_err_q.size(), 0);
        finish_now();
    end
endmodule
